// File: rtl/ifetch_unit.sv
// Instruction fetch FSM: one outstanding imem request, single-entry inst buffer; optional breakpoint halt under IFU_BRKPT_EN.
// Latency: inst_valid the cycle after imem_rvalid; backpressure: inst held (no new request) until inst_ready.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  output logic [31:0] pc_out,
  output logic [31:0] link_addr,
  input  logic [31:0] brk_addr,
  input  logic        resume,
  output logic        halted
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_VALID, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        drop_q, drop_d;
  logic        enter_req;
  logic [31:0] npc_al;
  logic [31:0] pc_inc;
  logic        unused_bits;

  assign npc_al = {npc_in[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  // enter_req marks every move into REQ with a freshly chosen PC (the breakpoint check point)
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    drop_d    = drop_q;
    enter_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d   = S_REQ;
        enter_req = 1'b1;
      end
      S_REQ: begin
        if (redirect) pc_d = npc_al;
        if (imem_gnt) begin
          state_d = S_WAIT;
          drop_d  = redirect;
        end else if (redirect) begin
          enter_req = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect) pc_d = npc_al;
        if (imem_rvalid) begin
          if (drop_q || redirect) begin
            state_d   = S_REQ;
            drop_d    = 1'b0;
            enter_req = 1'b1;
          end else begin
            inst_d  = imem_rdata;
            state_d = S_VALID;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      S_VALID: begin
        if (inst_ready) begin
          pc_d      = redirect ? npc_al : pc_inc;
          state_d   = S_REQ;
          enter_req = 1'b1;
        end else if (redirect) begin
          pc_d      = npc_al;
          state_d   = S_REQ;
          enter_req = 1'b1;
        end
      end
      S_HALT: begin
        if (redirect) pc_d = npc_al;
        if (resume) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef IFU_BRKPT_EN
    if (enter_req && (pc_d == brk_addr)) state_d = S_HALT;
`endif
  end

  always_comb begin
    imem_req   = (state_q == S_REQ);
    imem_addr  = pc_q;
    inst_valid = (state_q == S_VALID);
    inst       = inst_q;
    pc_out     = pc_q;
    link_addr  = pc_inc;
`ifdef IFU_BRKPT_EN
    halted     = (state_q == S_HALT);
`else
    halted     = 1'b0;
`endif
  end

`ifdef IFU_BRKPT_EN
  assign unused_bits = ^npc_in[1:0];
`else
  assign unused_bits = ^{npc_in[1:0], brk_addr, resume, enter_req};
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed fetch scenarios plus a randomized run scored against a transaction-level PC/instruction model.
// Memory returns a word derived from its address, so any stale or misdirected word shows up as an inst mismatch.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc_in;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic [31:0] brk_addr;
  logic        resume;
  logic        halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .npc_in(npc_in), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .pc_out(pc_out), .link_addr(link_addr),
    .brk_addr(brk_addr), .resume(resume), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; npc_in = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; resume = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_out, 32'h0000_3000);
    chk("rst_link", link_addr, 32'h0000_3004);
    chk("rst_inst", inst, 32'h0);
    chk("rst_vld", inst_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_halted", halted, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_seen"}, imem_req, 1);
  endtask

  // one request: grant on the first REQ cycle, data on the following cycle
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data);
    wait_req(tag);
    chk({tag, "_addr"}, imem_addr, addr);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk({tag, "_wait_noreq"}, imem_req, 0);
    chk({tag, "_wait_novld"}, inst_valid, 0);
    imem_rvalid = 1'b1; imem_rdata = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk({tag, "_vld"}, inst_valid, 1);
    chk({tag, "_inst"}, inst, data);
    chk({tag, "_pc"}, pc_out, addr);
    chk({tag, "_link"}, link_addr, addr + 32'd4);
  endtask

  initial begin
    logic [31:0] exp_pc, pend;
    logic        outstanding;
    int          delay, consumed;

    brk_addr = 32'h0000_0002;
    inst_ready = 1'b0;

    // first fetch timing, then hold the buffer under backpressure
    do_reset();
    chk("c1_idle_req", imem_req, 0);
    @(negedge clk);
    chk("c2_req", imem_req, 1);
    serve("first", 32'h0000_3000, 32'h2408_0005);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_vld", inst_valid, 1);
      chk("hold_inst", inst, 32'h2408_0005);
      chk("hold_pc", pc_out, 32'h0000_3000);
      chk("hold_noreq", imem_req, 0);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("after_hold_req", imem_req, 1);
    chk("after_hold_addr", imem_addr, 32'h0000_3004);
    chk("after_hold_novld", inst_valid, 0);

    // sequential stream with consumer always ready
    do_reset();
    inst_ready = 1'b1;
    serve("seq0", 32'h0000_3000, 32'h1111_0000);
    serve("seq1", 32'h0000_3004, 32'h1111_0004);
    serve("seq2", 32'h0000_3008, 32'h1111_0008);

    // redirect while waiting for data drops the returning word
    wait_req("drop");
    chk("drop_addr0", imem_addr, 32'h0000_300C);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    redirect = 1'b1; npc_in = 32'h0000_3040;
    @(negedge clk);
    redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    chk("drop_novld0", inst_valid, 0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("drop_novld1", inst_valid, 0);
    chk("drop_req", imem_req, 1);
    chk("drop_addr1", imem_addr, 32'h0000_3040);
    serve("drop_next", 32'h0000_3040, 32'h2222_3040);

    // PC wrap at 2^32, with low npc bits ignored
    wait_req("wrap");
    redirect = 1'b1; npc_in = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    serve("wrap", 32'hFFFF_FFFC, 32'h3333_3333);
    wait_req("wrap_next");
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);

`ifdef IFU_BRKPT_EN
    brk_addr = 32'h0000_3008;
    do_reset();
    inst_ready = 1'b1;
    serve("bk0", 32'h0000_3000, 32'h4444_0000);
    serve("bk1", 32'h0000_3004, 32'h4444_0004);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bk_halted", halted, 1);
      chk("bk_noreq", imem_req, 0);
    end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("bk_resumed", halted, 0);
    chk("bk_req", imem_req, 1);
    chk("bk_addr", imem_addr, 32'h0000_3008);
    serve("bk2", 32'h0000_3008, 32'h4444_0008);
    brk_addr = 32'h0000_0002;
`endif

    // randomized traffic against a PC-stream model
    inst_ready = 1'b0;
    do_reset();
    exp_pc = 32'h0000_3000;
    outstanding = 1'b0;
    pend = '0;
    delay = 0;
    consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("r_pc", pc_out, exp_pc);
      chk("r_link", link_addr, exp_pc + 32'd4);
      chk("r_halted", halted, 0);
      if (imem_req) begin
        chk("r_addr", imem_addr, exp_pc);
        chk("r_one_outstanding", outstanding, 0);
      end
      if (inst_valid) begin
        chk("r_inst", inst, mem_word(exp_pc));
        chk("r_vld_noreq", imem_req, 0);
      end
      imem_rvalid = 1'b0;
      if (outstanding) begin
        if (delay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend);
          outstanding = 1'b0;
        end else begin
          delay--;
        end
      end
      imem_gnt = imem_req && ($urandom_range(0, 2) != 0);
      if (imem_gnt) begin
        outstanding = 1'b1;
        pend = imem_addr;
        delay = $urandom_range(0, 3);
      end
      redirect   = (cyc > 2) && ($urandom_range(0, 7) == 0);
      npc_in     = $urandom;
      inst_ready = $urandom_range(0, 1);
      if (inst_valid && inst_ready) consumed++;
      if (redirect) exp_pc = {npc_in[31:2], 2'b00};
      else if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
      @(negedge clk);
    end
    chk("r_progress", consumed >= 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 npc_in  in  32  next-PC target from next-PC logic, used only when redirect=1.
REQ-005 redirect  in  1  taken branch/jump/jr; load npc_in as next fetch PC.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  fetch address, equal to pc_out while imem_req=1.
REQ-008 imem_gnt  in  1  memory accepted the request this cycle.
REQ-009 imem_rvalid  in  1  read data valid, at least one cycle after grant.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 inst_valid  out  1  inst holds a valid instruction for decode.
REQ-012 inst  out  32  buffered instruction word.
REQ-013 inst_ready  in  1  decode consumes inst this cycle when inst_valid=1.
REQ-014 pc_out  out  32  PC of the instruction being fetched or buffered.
REQ-015 link_addr  out  32  pc_out + 4, modulo 2^32.
REQ-016 brk_addr  in  32  breakpoint address, used only under IFU_BRKPT_EN.
REQ-017 resume  in  1  leave halt, used only under IFU_BRKPT_EN.
REQ-018 halted  out  1  fetch stopped at breakpoint.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, VALID, HALT; encoding is free.
REQ-020 IDLE SHALL last one cycle after reset release, then go to REQ.
REQ-021 REQ: imem_req=1, imem_addr=pc_out; on imem_gnt=1 go to WAIT.
REQ-022 WAIT: imem_req=0; on imem_rvalid=1 with drop flag clear, capture imem_rdata into inst and go to VALID; with drop set, discard data, clear drop, go to REQ.
REQ-023 VALID: inst_valid=1, inst stable; on inst_ready=1, pc_out <= (redirect ? npc_in : pc_out+4) and go to REQ next cycle.
REQ-024 Redirect outside a VALID handshake: in REQ, pc_out <= npc_in and requesting continues with the new address next cycle; in WAIT, pc_out <= npc_in and drop is set; in VALID without inst_ready, buffer is discarded, pc_out <= npc_in, go to REQ.
REQ-025 Redirect and imem_rvalid in the same WAIT cycle SHALL discard the data and go to REQ with npc_in.
REQ-026 At most one request SHALL be outstanding; inst_valid SHALL be 0 in every state except VALID.
REQ-027 PC arithmetic SHALL wrap at 32 bits (32'hFFFF_FFFC + 4 = 0); pc_out[1:0] SHALL always be 00 (npc_in[1:0] ignored).
REQ-028 Fetch-to-inst_valid latency SHALL be one cycle after the imem_rvalid cycle; no combinational path from imem_rdata to inst.

Reset
REQ-029 While rst_n=0: state=IDLE, pc_out=RESET_PC, link_addr=RESET_PC+4, inst=0, inst_valid=0, imem_req=0, drop=0, halted=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it; a late imem_rvalid after release SHALL be ignored unless in WAIT.

Configuration
REQ-031 Macro IFU_BRKPT_EN defined: on entering REQ with pc_out==brk_addr, go to HALT instead, imem_req=0, halted=1; resume=1 returns to REQ for that same PC with breakpoint suppressed for that one fetch; redirect in HALT updates pc_out and stays halted.
REQ-032 Macro undefined: HALT unreachable, halted tied 0, brk_addr and resume ignored; ports remain present.

Verification
REQ-033 Reset release, gnt and rvalid one cycle each, rdata=32'h2408_0005 -> imem_addr=32'h0000_3000, inst_valid on cycle 4 with inst=32'h2408_0005, link_addr=32'h0000_3004.
REQ-034 Three fetches with inst_ready tied 1, no redirect -> imem_addr sequence 3000, 3004, 3008; pc_out=32'h0000_3008 on third instruction.
REQ-035 inst_ready held 0 for 5 cycles in VALID -> inst and pc_out stable, imem_req=0 throughout.
REQ-036 redirect=1, npc_in=32'h0000_3040 during WAIT, rvalid next cycle -> data discarded, next imem_addr=32'h0000_3040, no inst_valid for the dropped word.
REQ-037 pc_out=32'hFFFF_FFFC consumed without redirect -> next imem_addr=32'h0000_0000.
REQ-038 IFU_BRKPT_EN, brk_addr=32'h0000_3008 -> halted=1 with no request to 3008; resume pulse -> request to 3008 issued, halted=0.
